// File: rtl/writeback_pkg.sv
// Shared types for the register-file writeback arbiter: request record and arbiter FSM states.
package writeback_pkg;

  localparam int NUM_LANES     = 16;
  localparam int REG_IDX_WIDTH = 5;
  localparam int VALUE_WIDTH   = 512;

  // "reg" is a keyword, so the destination register field is called dest_reg
  typedef struct packed {
    logic [REG_IDX_WIDTH-1:0] dest_reg;
    logic                     is_vector;
    logic [NUM_LANES-1:0]     mask;
    logic [VALUE_WIDTH-1:0]   value;
  } wb_req_t;

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_return_fifo.sv
// Synchronous FIFO buffering late load returns until the register-file write port is free.
module wb_return_fifo
  import writeback_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  wb_req_t      push_data,
  input  logic         pop,
  output wb_req_t      head_data,
  output logic [PTR_W:0] count,
  output logic         full,
  output logic         empty
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  wb_req_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Payload storage carries no reset; only pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];
  assign full      = (count == CNT_FULL);
  assign empty     = (count == '0);

endmodule

// File: rtl/writeback_arbiter.sv
// Shares the register-file write port between pipeline results (always first) and buffered load returns.
module writeback_arbiter
  import writeback_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     pipe_has_writeback_i,
  input  logic [REG_IDX_WIDTH-1:0] pipe_writeback_reg_i,
  input  logic                     pipe_writeback_is_vector_i,
  input  logic [NUM_LANES-1:0]     pipe_mask_i,
  input  logic [VALUE_WIDTH-1:0]   pipe_value_i,
  input  logic                     lr_valid_i,
  output logic                     lr_ready_o,
  input  logic [REG_IDX_WIDTH-1:0] lr_reg_i,
  input  logic                     lr_is_vector_i,
  input  logic [NUM_LANES-1:0]     lr_mask_i,
  input  logic [VALUE_WIDTH-1:0]   lr_value_i,
  output logic                     rf_enable_o,
  output logic [REG_IDX_WIDTH-1:0] rf_reg_o,
  output logic                     rf_is_vector_o,
  output logic [NUM_LANES-1:0]     rf_mask_o,
  output logic [VALUE_WIDTH-1:0]   rf_value_o,
  output logic                     rf_source_o,
  output logic                     pipe_stall_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
  localparam logic [AGE_W-1:0] AGE_TRIP = AGE_W'(STARVE_LIMIT - 1);

  wb_req_t          pipe_req;
  wb_req_t          lr_req;
  wb_req_t          head_req;
  wb_req_t          rf_req;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [AGE_W-1:0] age;
  logic [AGE_W-1:0] age_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             rf_enable;
  logic             rf_source;
  arb_state_t       state;
  arb_state_t       state_next;

  assign pipe_req = '{dest_reg: pipe_writeback_reg_i, is_vector: pipe_writeback_is_vector_i,
                      mask: pipe_mask_i, value: pipe_value_i};
  assign lr_req   = '{dest_reg: lr_reg_i, is_vector: lr_is_vector_i,
                      mask: lr_mask_i, value: lr_value_i};

  assign lr_ready_o = !fifo_full;
  assign push       = lr_valid_i && !fifo_full;
  assign pop        = !pipe_has_writeback_i && !fifo_empty;

  wb_return_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(lr_req),
    .pop      (pop),
    .head_data(head_req),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Next-state occupancy and head age feed the bubble decision so stall lands with the state change
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase

    age_next = age;
    if (pop || fifo_empty) begin
      age_next = '0;
    end else if (age != AGE_MAX) begin
      age_next = age + AGE_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (age_next >= AGE_TRIP || count_next >= CNT_HIGH) state_next = BUBBLE;
      end
      BUBBLE: begin
        if (pop && count_next < CNT_HIGH && age_next == '0) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      age   <= '0;
    end else begin
      state <= state_next;
      age   <= age_next;
    end
  end

  // Output register: fields hold their last written values on idle cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_enable <= 1'b0;
      rf_source <= 1'b0;
      rf_req    <= '0;
    end else if (pipe_has_writeback_i) begin
      rf_enable <= 1'b1;
      rf_source <= 1'b0;
      rf_req    <= pipe_req;
    end else if (pop) begin
      rf_enable <= 1'b1;
      rf_source <= 1'b1;
      rf_req    <= head_req;
    end else begin
      rf_enable <= 1'b0;
    end
  end

  assign rf_enable_o    = rf_enable;
  assign rf_source_o    = rf_source;
  assign rf_reg_o       = rf_req.dest_reg;
  assign rf_is_vector_o = rf_req.is_vector;
  assign rf_mask_o      = rf_req.mask;
  assign rf_value_o     = rf_req.value;
  assign pipe_stall_o   = (state == BUBBLE);

endmodule
